banco_registros_param: RTL
==========================

Name: banco_registros_param

Overview:
- Parametrised, clocked successor to the CPU's single-write combinational register bank, used by the datapath decode/writeback stages.
- Features:
  - N read ports with registered outputs.
  - Two write ports (ALU writeback and load writeback) with fixed priority.
  - Write-first bypass.
  - Optional hardwired-zero register 0.
  - Per-register busy scoreboard for hazard detection.
- Storage is flops, cleared by reset; no initialisation file.

Parameters:
- WIDTH, 32: data width of each register.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, and is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- AR  in  NUM_RD*ADDR_W  read addresses; port k = AR[k*ADDR_W +: ADDR_W].
- DR  out  NUM_RD*WIDTH  read data, registered; port k = DR[k*WIDTH +: WIDTH].
- BusyR  out  NUM_RD  registered busy flag of the register addressed on each read port.
- RegWrite0  in  1  write enable, port 0.
- AWrite0  in  ADDR_W  write address, port 0.
- DataIn0  in  WIDTH  write data, port 0.
- RegWrite1  in  1  write enable, port 1 (higher priority).
- AWrite1  in  ADDR_W  write address, port 1.
- DataIn1  in  WIDTH  write data, port 1.
- SetBusy  in  1  mark register ASet busy (instruction issued, result pending).
- ASet  in  ADDR_W  register to mark busy.
- BusyVec  out  2**ADDR_W  raw scoreboard, bit i = register i busy; direct from flops.

Behaviour:
- Reset (async assert, sync-style release on next edge):
  - all registers = 0, all busy bits = 0, DR = 0, BusyR = 0, BusyVec = 0.
  - Reset mid-operation discards any write or set presented in that cycle.
- Writes:
  - Commit on the rising edge when RegWrite0 or RegWrite1 is set.
  - Same address on both ports in one cycle: port 1 data is stored; port 0 is dropped.
  - ZERO_REG=1: writes to address 0 are ignored on both ports.
- Reads:
  - Latency is 1 cycle: DR port k after edge t = contents of register AR_k as they stand after the writes committed at edge t (write-first).
  - Bypass priority: DataIn1 if it matches, else DataIn0, else the stored value.
  - ZERO_REG=1 and AR_k=0: DR port k = 0 regardless of writes.
  - Read ports are fully independent; the same address on several ports is legal.
- Scoreboard:
  - A write on either port to address a clears busy[a] at the edge.
  - SetBusy sets busy[ASet] at the edge.
  - Set and clear of the same address in the same cycle: set wins, because a new producer supersedes the old one.
  - ZERO_REG=1: busy[0] is held at 0.
- BusyR:
  - BusyR_k after edge t = busy[AR_k] post-update at edge t, bypassed the same way as data.
  - Consistent with DR on the same cycle.
- Addresses are always in range (depth = 2**ADDR_W), so there is no out-of-range case.
- No combinational path from inputs to DR/BusyR. BusyVec is flop-only.

Test Plan:
- Reset: load reg 5 = 32'hDEAD_BEEF, assert rst mid-cycle -> DR, BusyVec, and reg 5 immediately read 0; after release, reading reg 5 gives 0.
- Basic: write reg 3 = 32'h0000_1234 via port 0, next cycle AR port 0 = 3 -> DR0 = 32'h0000_1234 one cycle later.
- Bypass/conflict:
  - Same cycle: port 0 writes reg 7 = 32'h11, port 1 writes reg 7 = 32'h22, AR0 = AR1 = 7 -> both DR ports = 32'h22 after that edge.
  - Reg 7 later reads 32'h22.
- Zero register: write reg 0 = 32'hFFFF_FFFF on both ports and SetBusy with ASet = 0 -> DR = 0, BusyR = 0, BusyVec[0] = 0.
- Scoreboard:
  - SetBusy reg 9 -> BusyVec[9] = 1; while busy, a read of reg 9 gives BusyR = 1.
  - Port 0 write to reg 9 -> bit clears.
  - SetBusy reg 9 and a write to reg 9 in the same cycle -> BusyVec[9] stays 1, and the data is stored.
- Parameter sweep: WIDTH=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0:
  - Reg 0 write 16'hABCD is readable.
  - 3 ports read regs 0/1/7 independently with correct values.

Source files
------------

// File: rtl/banco_registros_param.sv
// Parametrised clocked register bank: N registered read ports, two prioritised write
// ports with write-first bypass, optional hardwired zero register and a busy scoreboard.
module banco_registros_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   AR,
  output logic [NUM_RD*WIDTH-1:0]    DR,
  output logic [NUM_RD-1:0]          BusyR,
  input  logic                       RegWrite0,
  input  logic [ADDR_W-1:0]          AWrite0,
  input  logic [WIDTH-1:0]           DataIn0,
  input  logic                       RegWrite1,
  input  logic [ADDR_W-1:0]          AWrite1,
  input  logic [WIDTH-1:0]           DataIn1,
  input  logic                       SetBusy,
  input  logic [ADDR_W-1:0]          ASet,
  output logic [(2**ADDR_W)-1:0]     BusyVec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]         mem_q [DEPTH];
  logic [WIDTH-1:0]         mem_d [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*WIDTH-1:0]  dr_q, dr_d;
  logic [NUM_RD-1:0]        busyr_q, busyr_d;
  logic                     we0, we1, set_en;
  logic [ADDR_W-1:0]        ra;

  // Register 0 swallows writes and busy-sets when it is hardwired to zero.
  assign we0    = RegWrite0 && !((ZERO_REG != 0) && (AWrite0 == '0));
  assign we1    = RegWrite1 && !((ZERO_REG != 0) && (AWrite1 == '0));
  assign set_en = SetBusy   && !((ZERO_REG != 0) && (ASet    == '0));

  // Next state of storage and scoreboard; the read stage samples this post-write view.
  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    dr_d    = '0;
    busyr_d = '0;
    ra      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]  = (we1 && (AWrite1 == ADDR_W'(i))) ? DataIn1 :
                  (we0 && (AWrite0 == ADDR_W'(i))) ? DataIn0 : mem_q[i];
      // A fresh producer outranks the completing one on the same register.
      busy_d[i] = (set_en && (ASet == ADDR_W'(i))) ? 1'b1 :
                  ((we1 && (AWrite1 == ADDR_W'(i))) ||
                   (we0 && (AWrite0 == ADDR_W'(i)))) ? 1'b0 : busy_q[i];
    end
    for (int k = 0; k < NUM_RD; k++) begin
      ra                      = AR[k*ADDR_W +: ADDR_W];
      dr_d[k*WIDTH +: WIDTH]  = mem_d[ra];
      busyr_d[k]              = busy_d[ra];
    end
  end

  // State and registered read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q  <= '0;
      dr_q    <= '0;
      busyr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q  <= busy_d;
      dr_q    <= dr_d;
      busyr_q <= busyr_d;
    end
  end

  assign DR      = dr_q;
  assign BusyR   = busyr_q;
  assign BusyVec = busy_q;

endmodule
